// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared types and constants for the UART receive frame controller.
//   rx_state_e      : receive FSM states
//   START_BIT       : bit index of the start bit
//   PAR_BIT         : bit index of the parity bit (when present)
//   FRAME_LEN_*     : total bits per frame without / with parity
//   legal_prescale(): maps any prescale value onto a supported ratio
//   frame_len()     : frame length for a given parity setting
// -----------------------------------------------------------------------------
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam logic [3:0] START_BIT        = 4'd0;
  localparam logic [3:0] PAR_BIT          = 4'd9;
  localparam logic [3:0] FRAME_LEN_NO_PAR = 4'd10;
  localparam logic [3:0] FRAME_LEN_PAR    = 4'd11;

  // Only 8, 16 and 32 are supported oversampling ratios; anything else
  // falls back to the smallest one.
  function automatic logic [5:0] legal_prescale(input logic [5:0] pre);
    case (pre)
      6'd8, 6'd16, 6'd32: return pre;
      default:            return 6'd8;
    endcase
  endfunction

  function automatic logic [3:0] frame_len(input logic par_en);
    return par_en ? FRAME_LEN_PAR : FRAME_LEN_NO_PAR;
  endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_sampler.sv
// -----------------------------------------------------------------------------
// rx_data_sampler
// Three-point majority voter for one UART bit. RX_IN is captured at oversample
// indices P/2-1, P/2 and P/2+1; the vote is published at index P/2+2.
// Ports:
//   CLK, RST        : clock, asynchronous active-low reset
//   i_rx_in         : synchronised serial line
//   i_edge_cnt      : oversample index within the current bit
//   i_prescale      : latched oversampling ratio P
//   o_vote          : combinational majority of the three captured samples
//   o_vote_stb      : high in the cycle the vote is taken (index P/2+2)
//   o_sampled_bit   : registered vote, held until the next bit's vote
// -----------------------------------------------------------------------------
module rx_data_sampler
  import uart_rx_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_rx_in,
  input  logic [5:0] i_edge_cnt,
  input  logic [5:0] i_prescale,
  output logic       o_vote,
  output logic       o_vote_stb,
  output logic       o_sampled_bit
);

  logic [5:0] w_half;
  logic [2:0] r_samples;
  logic       r_sampled_bit;

  assign w_half     = i_prescale >> 1;
  assign o_vote     = (r_samples[0] & r_samples[1]) |
                      (r_samples[0] & r_samples[2]) |
                      (r_samples[1] & r_samples[2]);
  assign o_vote_stb = (i_edge_cnt == w_half + 6'd2);

  // While the controller idles, edge_cnt is held at 0, which never matches
  // any sample point (P >= 8), so no gating on FSM state is needed here.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_samples     <= '0;
      r_sampled_bit <= 1'b0;
    end else begin
      if (i_edge_cnt == w_half - 6'd1) r_samples[0] <= i_rx_in;
      if (i_edge_cnt == w_half)        r_samples[1] <= i_rx_in;
      if (i_edge_cnt == w_half + 6'd1) r_samples[2] <= i_rx_in;
      if (o_vote_stb)                  r_sampled_bit <= o_vote;
    end
  end

  assign o_sampled_bit = r_sampled_bit;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_ctrl
// UART receive frame controller: tracks oversample/bit position, runs the
// IDLE/START/DATA/PARITY/STOP FSM, deserialises the data byte and flags
// frame outcomes. Parity itself is checked by an external block that reads
// P_DATA and sampled_bit while par_chk_en is high.
// Ports:
//   CLK          : oversampling clock
//   RST          : asynchronous active-low reset
//   RX_IN        : synchronised serial line, idle high
//   PAR_EN       : frame carries a parity bit (latched at frame start)
//   prescale     : oversampling ratio 8/16/32 (latched at frame start)
//   par_err      : registered result from the external parity checker
//   edge_cnt     : oversample index within the current bit
//   bit_cnt      : bit index within the frame
//   sampled_bit  : majority-voted value of the current bit
//   P_DATA       : deserialised data byte
//   par_chk_en   : enables the external parity checker during STOP
//   data_valid   : one-cycle pulse for a good frame
//   stp_err      : one-cycle pulse for a bad stop bit
//   strt_glitch  : one-cycle pulse for a false start bit
// -----------------------------------------------------------------------------
module uart_rx_frame_ctrl
  import uart_rx_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic       PAR_EN,
  input  logic [5:0] prescale,
  input  logic       par_err,
  output logic [5:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       sampled_bit,
  output logic [7:0] P_DATA,
  output logic       par_chk_en,
  output logic       data_valid,
  output logic       stp_err,
  output logic       strt_glitch
);

  rx_state_e  r_state;
  rx_state_e  w_next_state;

  logic [5:0] r_prescale;
  logic       r_par_en;
  logic [5:0] r_edge_cnt;
  logic [3:0] r_bit_cnt;
  logic [7:0] r_data;
  logic       r_par_chk_en;
  logic       r_data_valid;
  logic       r_stp_err;
  logic       r_strt_glitch;

  logic       w_last_edge;
  logic       w_vote;
  logic       w_vote_stb;
  logic       w_sampled_bit;
  logic [2:0] w_data_idx;
  logic [3:0] w_stop_bit;
  logic       w_data_valid;
  logic       w_stp_err;
  logic       w_strt_glitch;

  rx_data_sampler u_sampler (
    .CLK           (CLK),
    .RST           (RST),
    .i_rx_in       (RX_IN),
    .i_edge_cnt    (r_edge_cnt),
    .i_prescale    (r_prescale),
    .o_vote        (w_vote),
    .o_vote_stb    (w_vote_stb),
    .o_sampled_bit (w_sampled_bit)
  );

  assign w_last_edge = (r_edge_cnt == r_prescale - 6'd1);
  assign w_stop_bit  = frame_len(r_par_en) - 4'd1;
  // Data bits 1..8 map to P_DATA[0..7]; bit 8 wraps to 0 in three bits,
  // so subtracting one in three bits lands on index 7 as required.
  assign w_data_idx  = r_bit_cnt[2:0] - 3'd1;

  // ---------------------------------------------------------------------------
  // State register and per-frame configuration
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= IDLE;
      r_prescale <= 6'd8;
      r_par_en   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE && w_next_state == START) begin
        r_prescale <= legal_prescale(prescale);
        r_par_en   <= PAR_EN;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and pulse decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would infer a latch.
    w_next_state  = r_state;
    w_data_valid  = 1'b0;
    w_stp_err     = 1'b0;
    w_strt_glitch = 1'b0;
    case (r_state)
      IDLE: begin
        if (!RX_IN) w_next_state = START;
      end
      START: begin
        if (w_last_edge) begin
          if (w_sampled_bit) begin
            w_next_state  = IDLE;
            w_strt_glitch = 1'b1;
          end else begin
            w_next_state  = DATA;
          end
        end
      end
      DATA: begin
        // Parity follows the last data bit only if the frame is long enough
        // to place the stop bit after PAR_BIT.
        if (w_last_edge && r_bit_cnt == PAR_BIT - 4'd1)
          w_next_state = (w_stop_bit > PAR_BIT) ? PARITY : STOP;
      end
      PARITY: begin
        if (w_last_edge) w_next_state = STOP;
      end
      STOP: begin
        if (w_last_edge) begin
          w_next_state = IDLE;
          if (!w_sampled_bit)
            w_stp_err = 1'b1;
          else if (!r_par_chk_en || !par_err)
            w_data_valid = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Edge / bit counters: cleared in IDLE and on the way back to it, so the
  // next frame always starts from START_BIT, edge 0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= START_BIT;
    end else if (r_state == IDLE || w_next_state == IDLE) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= START_BIT;
    end else if (w_last_edge) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= r_bit_cnt + 4'd1;
    end else begin
      r_edge_cnt <= r_edge_cnt + 6'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Data shift-in, parity-check enable and registered status pulses
  // ---------------------------------------------------------------------------
  // NOTE: P_DATA is a plain register (not a memory array), so it is reset
  // like any other flop and must read 0 while RST is low.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_data        <= '0;
      r_par_chk_en  <= 1'b0;
      r_data_valid  <= 1'b0;
      r_stp_err     <= 1'b0;
      r_strt_glitch <= 1'b0;
    end else begin
      if (r_state == DATA && w_vote_stb) r_data[w_data_idx] <= w_vote;
      // Set on PARITY->STOP, held through STOP, cleared on leaving STOP.
      r_par_chk_en  <= (w_next_state == STOP) &&
                       (r_state == PARITY || r_par_chk_en);
      r_data_valid  <= w_data_valid;
      r_stp_err     <= w_stp_err;
      r_strt_glitch <= w_strt_glitch;
    end
  end

  assign edge_cnt    = r_edge_cnt;
  assign bit_cnt     = r_bit_cnt;
  assign sampled_bit = w_sampled_bit;
  assign P_DATA      = r_data;
  assign par_chk_en  = r_par_chk_en;
  assign data_valid  = r_data_valid;
  assign stp_err     = r_stp_err;
  assign strt_glitch = r_strt_glitch;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_frame_ctrl
// Directed bench for uart_rx_frame_ctrl. Includes a small even-parity checker
// model that plays the downstream block driving par_err.
// -----------------------------------------------------------------------------
module tb_uart_rx_frame_ctrl;

  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic [5:0] prescale;
  logic       par_err;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sampled_bit;
  logic [7:0] P_DATA;
  logic       par_chk_en;
  logic       data_valid;
  logic       stp_err;
  logic       strt_glitch;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int dv_cnt = 0;
  int stp_cnt = 0;
  int gl_cnt = 0;
  int dv_cyc = 0;
  logic [7:0] dv_data = 8'h00;
  logic [7:0] dv_prev = 8'h00;

  uart_rx_frame_ctrl dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .PAR_EN      (PAR_EN),
    .prescale    (prescale),
    .par_err     (par_err),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .sampled_bit (sampled_bit),
    .P_DATA      (P_DATA),
    .par_chk_en  (par_chk_en),
    .data_valid  (data_valid),
    .stp_err     (stp_err),
    .strt_glitch (strt_glitch)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Downstream even-parity checker: evaluates at STOP edge 1 while
  // sampled_bit still holds the parity sample; registered result.
  always @(posedge CLK or negedge RST) begin
    if (!RST)
      par_err <= 1'b0;
    else if (par_chk_en && edge_cnt == 6'd1)
      par_err <= (^P_DATA) ^ sampled_bit;
  end

  // Pulse monitors.
  always @(negedge CLK) begin
    if (data_valid) begin
      dv_cnt  = dv_cnt + 1;
      dv_prev = dv_data;
      dv_data = P_DATA;
      dv_cyc  = cyc;
    end
    if (stp_err)     stp_cnt = stp_cnt + 1;
    if (strt_glitch) gl_cnt  = gl_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; holds RX_IN for p clock cycles.
  task automatic drive_bit(input logic v, input int p);
    RX_IN = v;
    repeat (p) @(posedge CLK);
    #1;
  endtask

  // Start bit, data bits (LSB first) and optional parity. The configuration
  // inputs are changed to new_pre/new_paren right after the start bit.
  task automatic send_head(input logic [7:0] data, input logic with_par,
                           input logic par_val, input int p,
                           input logic [5:0] new_pre, input logic new_paren);
    drive_bit(1'b0, p);
    prescale = new_pre;
    PAR_EN   = new_paren;
    for (int i = 0; i < 8; i++) drive_bit(data[i], p);
    if (with_par) drive_bit(par_val, p);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic with_par,
                            input logic par_val, input logic stop_val, input int p,
                            input logic [5:0] new_pre, input logic new_paren);
    send_head(data, with_par, par_val, p, new_pre, new_paren);
    drive_bit(stop_val, p);
    RX_IN = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_edge_cnt"},    32'(edge_cnt),    32'd0);
    check({tag, "_bit_cnt"},     32'(bit_cnt),     32'd0);
    check({tag, "_sampled_bit"}, 32'(sampled_bit), 32'd0);
    check({tag, "_p_data"},      32'(P_DATA),      32'd0);
    check({tag, "_par_chk_en"},  32'(par_chk_en),  32'd0);
    check({tag, "_data_valid"},  32'(data_valid),  32'd0);
    check({tag, "_stp_err"},     32'(stp_err),     32'd0);
    check({tag, "_strt_glitch"}, 32'(strt_glitch), 32'd0);
  endtask

  int dv0, stp0, gl0, start_cyc, lat;

  initial begin
    RST      = 1'b0;
    RX_IN    = 1'b1;
    PAR_EN   = 1'b0;
    prescale = 6'd8;

    // ---- reset state ----
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    RST = 1'b1;
    @(posedge CLK); #1;
    repeat (2) @(posedge CLK); #1;

    // ---- P=8, no parity, 0xA5 ----
    dv0 = dv_cnt; stp0 = stp_cnt;
    start_cyc = cyc;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 8, 6'd8, 1'b0);
    repeat (4) @(posedge CLK); #1;
    lat = dv_cyc - start_cyc - 1;
    check("a5_p_data",     32'(P_DATA),       32'hA5);
    check("a5_dv_count",   32'(dv_cnt - dv0), 32'd1);
    check("a5_dv_data",    32'(dv_data),      32'hA5);
    check("a5_latency_ok", 32'(lat >= 79 && lat <= 81), 32'd1);
    check("a5_stp_count",  32'(stp_cnt - stp0), 32'd0);
    check("a5_idle_edge",  32'(edge_cnt),     32'd0);
    check("a5_idle_bit",   32'(bit_cnt),      32'd0);

    // ---- P=16, parity, 0x3C with correct (even) parity 0 ----
    prescale = 6'd16; PAR_EN = 1'b1;
    dv0 = dv_cnt;
    send_head(8'h3C, 1'b1, 1'b0, 16, 6'd16, 1'b1);
    RX_IN = 1'b1;
    repeat (8) @(posedge CLK); #1;
    check("3c_par_chk_en_stop", 32'(par_chk_en), 32'd1);
    check("3c_par_err",         32'(par_err),    32'd0);
    repeat (8) @(posedge CLK); #1;
    repeat (4) @(posedge CLK); #1;
    check("3c_dv_count",        32'(dv_cnt - dv0), 32'd1);
    check("3c_p_data",          32'(P_DATA),       32'h3C);
    check("3c_par_chk_en_idle", 32'(par_chk_en),   32'd0);

    // ---- P=16, parity, 0x81 with wrong parity bit 1 ----
    dv0 = dv_cnt; stp0 = stp_cnt;
    send_head(8'h81, 1'b1, 1'b1, 16, 6'd16, 1'b1);
    RX_IN = 1'b1;
    repeat (8) @(posedge CLK); #1;
    check("81_par_err", 32'(par_err), 32'd1);
    repeat (8) @(posedge CLK); #1;
    repeat (4) @(posedge CLK); #1;
    check("81_dv_count",  32'(dv_cnt - dv0),   32'd0);
    check("81_stp_count", 32'(stp_cnt - stp0), 32'd0);
    check("81_idle_edge", 32'(edge_cnt),       32'd0);
    check("81_idle_bit",  32'(bit_cnt),        32'd0);
    check("81_p_data",    32'(P_DATA),         32'h81);

    // ---- P=8 false start: low for 3 cycles ----
    prescale = 6'd8; PAR_EN = 1'b0;
    dv0 = dv_cnt; gl0 = gl_cnt;
    RX_IN = 1'b0;
    repeat (3) @(posedge CLK); #1;
    RX_IN = 1'b1;
    repeat (12) @(posedge CLK); #1;
    check("glitch_count",  32'(gl_cnt - gl0),  32'd1);
    check("glitch_p_data", 32'(P_DATA),        32'h81);
    check("glitch_dv",     32'(dv_cnt - dv0),  32'd0);
    check("glitch_edge",   32'(edge_cnt),      32'd0);
    check("glitch_bit",    32'(bit_cnt),       32'd0);

    // ---- P=32, bad stop bit, then back-to-back 0x00 / 0xFF ----
    prescale = 6'd32; PAR_EN = 1'b0;
    dv0 = dv_cnt; stp0 = stp_cnt;
    send_frame(8'h33, 1'b0, 1'b0, 1'b0, 32, 6'd32, 1'b0);
    repeat (4) @(posedge CLK); #1;
    check("stp_count", 32'(stp_cnt - stp0), 32'd1);
    check("stp_dv",    32'(dv_cnt - dv0),   32'd0);
    dv0 = dv_cnt;
    send_frame(8'h00, 1'b0, 1'b0, 1'b1, 32, 6'd32, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 32, 6'd32, 1'b0);
    repeat (4) @(posedge CLK); #1;
    check("b2b_dv_count", 32'(dv_cnt - dv0), 32'd2);
    check("b2b_first",    32'(dv_prev),      32'h00);
    check("b2b_second",   32'(dv_data),      32'hFF);
    check("b2b_p_data",   32'(P_DATA),       32'hFF);

    // ---- reset at bit_cnt 4, then 0x5A with illegal prescale (-> 8) and
    //      mid-frame prescale / PAR_EN changes that must be ignored ----
    prescale = 6'd8; PAR_EN = 1'b0;
    dv0 = dv_cnt; stp0 = stp_cnt; gl0 = gl_cnt;
    drive_bit(1'b0, 8);
    for (int i = 0; i < 3; i++) drive_bit(1'b1, 8);
    RX_IN = 1'b1;
    repeat (4) @(posedge CLK); #1;
    check("rst_mid_bit_cnt", 32'(bit_cnt), 32'd4);
    RST = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    repeat (3) @(posedge CLK); #1;
    check("rst_hold_edge", 32'(edge_cnt), 32'd0);
    check("rst_hold_bit",  32'(bit_cnt),  32'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
    repeat (2) @(posedge CLK); #1;
    check("rst_no_dv",     32'(dv_cnt - dv0),   32'd0);
    check("rst_no_stp",    32'(stp_cnt - stp0), 32'd0);
    check("rst_no_glitch", 32'(gl_cnt - gl0),   32'd0);
    prescale = 6'd20;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 8, 6'd16, 1'b1);
    repeat (4) @(posedge CLK); #1;
    check("5a_dv_count", 32'(dv_cnt - dv0), 32'd1);
    check("5a_p_data",   32'(P_DATA),       32'h5A);
    check("5a_dv_data",  32'(dv_data),      32'h5A);
    check("5a_par_chk",  32'(par_chk_en),   32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
